// File: rtl/key_menu_ctrl.sv
// Key menu controller: turns debounced one-hot key levels into select/inc/dec/commit
// actions with long-press auto-repeat. Optional macro KEY_MENU_WRAP_EN: inc/dec wrap around instead of saturating.
module key_menu_ctrl #(
  parameter int                 NUM_PARAM = 4,
  parameter int                 PARAM_W   = 8,
  parameter logic [PARAM_W-1:0] PARAM_MAX = 8'd200,
  parameter int                 LONG_MS   = 500,
  parameter int                 REPEAT_MS = 100,
  parameter int                 IDX_W     = $clog2(NUM_PARAM)
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst,
  input  logic                           tick_1ms,
  input  logic [3:0]                     key_lvl,
  output logic [IDX_W-1:0]               sel_idx,
  output logic [NUM_PARAM*PARAM_W-1:0]   param_flat,
  output logic                           cfg_valid,
  output logic [IDX_W-1:0]               cfg_idx,
  output logic [PARAM_W-1:0]             cfg_data,
  input  logic                           cfg_ready,
  output logic                           busy
);

  localparam int CNT_W = $clog2((LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, COMMIT} state_t;

  state_t             state_q, state_d;
  logic [3:0]         key_q, key_prev_q, key_v, key_pos, held_lvl;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [PARAM_W-1:0] param_q [NUM_PARAM];
  logic [PARAM_W-1:0] param_d [NUM_PARAM];
  logic               up_q, up_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cfg_valid_q, cfg_valid_d;
  logic [IDX_W-1:0]   cfg_idx_q, cfg_idx_d;
  logic [PARAM_W-1:0] cfg_data_q, cfg_data_d;
  logic               busy_q, busy_d;

  function automatic logic [PARAM_W-1:0] step(input logic [PARAM_W-1:0] v, input logic up);
`ifdef KEY_MENU_WRAP_EN
    if (up) return (v >= PARAM_MAX) ? '0 : v + 1'b1;
    else    return (v == '0) ? PARAM_MAX : v - 1'b1;
`else
    if (up) return (v >= PARAM_MAX) ? v : v + 1'b1;
    else    return (v == '0) ? v : v - 1'b1;
`endif
  endfunction

  // Illegal chords collapse to "no key" before edge detection.
  assign key_v    = $onehot(key_lvl) ? key_lvl : 4'b0000;
  assign key_pos  = key_q & ~key_prev_q;
  assign held_lvl = up_q ? 4'b0010 : 4'b0100;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    param_d     = param_q;
    up_d        = up_q;
    cnt_d       = cnt_q;
    cfg_valid_d = cfg_valid_q;
    cfg_idx_d   = cfg_idx_q;
    cfg_data_d  = cfg_data_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (key_pos[0]) begin
          sel_d = (sel_q == IDX_W'(NUM_PARAM-1)) ? '0 : sel_q + 1'b1;
        end else if (key_pos[1] || key_pos[2]) begin
          up_d           = key_pos[1];
          param_d[sel_q] = step(param_q[sel_q], key_pos[1]);
          cnt_d          = '0;
          state_d        = HOLD;
        end else if (key_pos[3]) begin
          cfg_idx_d   = '0;
          cfg_data_d  = param_q[0];
          cfg_valid_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = COMMIT;
        end
      end
      HOLD, REPEAT: begin
        if (key_q != held_lvl) begin
          state_d = IDLE;
        end else if (tick_1ms) begin
          if (cnt_q == ((state_q == HOLD) ? CNT_W'(LONG_MS-1) : CNT_W'(REPEAT_MS-1))) begin
            param_d[sel_q] = step(param_q[sel_q], up_q);
            cnt_d          = '0;
            state_d        = REPEAT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      COMMIT: begin
        if (cfg_valid_q && cfg_ready) begin
          if (cfg_idx_q == IDX_W'(NUM_PARAM-1)) begin
            cfg_valid_d = 1'b0;
            busy_d      = 1'b0;
            state_d     = IDLE;
          end else begin
            cfg_idx_d  = cfg_idx_q + 1'b1;
            cfg_data_d = param_q[cfg_idx_d];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      key_prev_q  <= '0;
      sel_q       <= '0;
      up_q        <= 1'b0;
      cnt_q       <= '0;
      cfg_valid_q <= 1'b0;
      cfg_idx_q   <= '0;
      cfg_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_v;
      key_prev_q  <= key_q;
      sel_q       <= sel_d;
      up_q        <= up_d;
      cnt_q       <= cnt_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_idx_q   <= cfg_idx_d;
      cfg_data_q  <= cfg_data_d;
      busy_q      <= busy_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PARAM; gi++) begin : g_param
      always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) param_q[gi] <= '0;
        else         param_q[gi] <= param_d[gi];
      end
      assign param_flat[gi*PARAM_W +: PARAM_W] = param_q[gi];
    end
  endgenerate

  assign sel_idx   = sel_q;
  assign cfg_valid = cfg_valid_q;
  assign cfg_idx   = cfg_idx_q;
  assign cfg_data  = cfg_data_q;
  assign busy      = busy_q;

endmodule
